// File: rtl/conv_seq_ctrl.sv
// Result-path sequencer: runs the PE, 3x3-conv and 2x2 engines in order,
// then holds run_display_o for a fixed window, with per-stage timeout,
// abort, status flags and a saturating total-cycle counter.
//
// Engine handshake: run_x_o is high for every cycle the sequencer sits in
// that engine's stage; the engine answers with done_x_i, which is sampled
// only on a rising edge while that stage is active. One sampled done moves
// the sequencer to the next stage on that same edge, so run_x_o falls and
// the next run rises together. A done held longer, or a done for any other
// stage, has no effect.
module conv_seq_ctrl #(
    parameter int TIMEOUT     = 255,
    parameter int DISPLAY_LEN = 12,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             done_pe_i,
    input  logic             done_3x3_i,
    input  logic             done_2x2_i,
    output logic             run_pe_o,
    output logic             run_3x3_o,
    output logic             run_2x2_o,
    output logic             run_display_o,
    output logic [2:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PE   = 3'd1,
        S_3X3  = 3'd2,
        S_2X2  = 3'd3,
        S_DISP = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Last timer value a compute stage may spend waiting; the edge that
    // leaves it without a done goes to S_ERR.
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPLAY_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired;
    logic             busy_w;
    logic             accept_w;

    assign expired  = (timer_q >= TO_LAST);
    assign busy_w   = (state_q >= S_PE) && (state_q <= S_DONE);
    assign accept_w = ((state_q == S_IDLE) || (state_q == S_ERR)) && start_i;

    // State, stage timer and cycle counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: abort first, then done/timeout, then start.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: if (start_i) state_d = S_PE;
                S_PE: begin
                    if (done_pe_i)    state_d = S_3X3;
                    else if (expired) state_d = S_ERR;
                end
                S_3X3: begin
                    if (done_3x3_i)   state_d = S_2X2;
                    else if (expired) state_d = S_ERR;
                end
                S_2X2: begin
                    if (done_2x2_i)   state_d = S_DISP;
                    else if (expired) state_d = S_ERR;
                end
                S_DISP: if (timer_q == DISP_LAST) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stage timer: restarts on every state change, otherwise counts and sticks at max.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != CNT_MAX) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Total-cycle counter: cleared on start acceptance, counts through S_DONE,
    // frozen on abort, in S_ERR and in S_IDLE; saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (!abort_i) begin
            if (accept_w) begin
                cnt_d = '0;
            end else if (busy_w && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign run_pe_o      = (state_q == S_PE);
    assign run_3x3_o     = (state_q == S_3X3);
    assign run_2x2_o     = (state_q == S_2X2);
    assign run_display_o = (state_q == S_DISP);
    assign state_o       = state_q;
    assign busy_o        = busy_w;
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERR);
    assign cycle_cnt_o   = cnt_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl. A second instance with CNT_W=4 shares
// all inputs and is used for the counter saturation scenario.
module tb_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i, abort_i, done_pe_i, done_3x3_i, done_2x2_i;
    logic       run_pe_o, run_3x3_o, run_2x2_o, run_display_o;
    logic [2:0] state_o;
    logic       busy_o, done_o, err_o;
    logic [7:0] cycle_cnt_o;

    logic       run_pe_b, run_3x3_b, run_2x2_b, run_display_b;
    logic [2:0] state_b;
    logic       busy_b, done_b, err_b;
    logic [3:0] cycle_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    conv_seq_ctrl dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .done_pe_i(done_pe_i), .done_3x3_i(done_3x3_i), .done_2x2_i(done_2x2_i),
        .run_pe_o(run_pe_o), .run_3x3_o(run_3x3_o), .run_2x2_o(run_2x2_o),
        .run_display_o(run_display_o), .state_o(state_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .cycle_cnt_o(cycle_cnt_o)
    );

    conv_seq_ctrl #(.TIMEOUT(10), .DISPLAY_LEN(12), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .done_pe_i(done_pe_i), .done_3x3_i(done_3x3_i), .done_2x2_i(done_2x2_i),
        .run_pe_o(run_pe_b), .run_3x3_o(run_3x3_b), .run_2x2_o(run_2x2_b),
        .run_display_o(run_display_b), .state_o(state_b), .busy_o(busy_b),
        .done_o(done_b), .err_o(err_b), .cycle_cnt_o(cycle_cnt_b)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Start a run and act as the three engines: each done rises once its run
    // has been high for lat cycles (lat=0: never). Optionally aborts on the
    // given display cycle, or injects a stray done_3x3 during S_PE and a
    // stray start during S_2X2. Stops when the DUT reaches S_IDLE or S_ERR.
    task automatic run_seq(input int lat, input int abort_cyc, input bit bogus,
                           output int pe_hi, output int c3_hi, output int c2_hi,
                           output int disp_hi, output int dn, output bit timed_out);
        int pe_len = 0;
        int c3_len = 0;
        int c2_len = 0;
        pe_hi = 0; c3_hi = 0; c2_hi = 0; disp_hi = 0; dn = 0; timed_out = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (state_o == 3'd0 || state_o == 3'd6) begin
                timed_out = 1'b0;
                break;
            end
            abort_i = 1'b0;
            if (run_pe_o)      pe_hi++;
            if (run_3x3_o)     c3_hi++;
            if (run_2x2_o)     c2_hi++;
            if (run_display_o) disp_hi++;
            if (done_o)        dn++;
            pe_len = run_pe_o  ? pe_len + 1 : 0;
            c3_len = run_3x3_o ? c3_len + 1 : 0;
            c2_len = run_2x2_o ? c2_len + 1 : 0;
            done_pe_i  = (lat > 0) && run_pe_o && (pe_len >= lat);
            done_3x3_i = ((lat > 0) && run_3x3_o && (c3_len >= lat)) || (bogus && run_pe_o);
            done_2x2_i = (lat > 0) && run_2x2_o && (c2_len >= lat);
            start_i    = bogus && run_2x2_o;
            if (abort_cyc > 0 && run_display_o && disp_hi == abort_cyc) abort_i = 1'b1;
            tick();
        end
        start_i = 1'b0; abort_i = 1'b0;
        done_pe_i = 1'b0; done_3x3_i = 1'b0; done_2x2_i = 1'b0;
        if (timed_out) $display("FAIL run_seq_bound: sequence did not end within 400 cycles");
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_i = 1'b0; abort_i = 1'b0;
        done_pe_i = 1'b0; done_3x3_i = 1'b0; done_2x2_i = 1'b0;
        #2;
        n_checks++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else n_pass++;
        n_checks++; if ({run_pe_o, run_3x3_o, run_2x2_o, run_display_o} !== 4'b0)
            $display("FAIL reset_runs: got %b expected 0000", {run_pe_o, run_3x3_o, run_2x2_o, run_display_o}); else n_pass++;
        n_checks++; if ({busy_o, done_o, err_o} !== 3'b0)
            $display("FAIL reset_status: got %b expected 000", {busy_o, done_o, err_o}); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt_o); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        done_pe_i = 1'b1;
        tick();
        done_pe_i = 1'b0;
        n_checks++; if (state_o !== 3'd2) $display("FAIL t1_in_3x3: got %0d expected 2", state_o); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (state_o !== 3'd0) $display("FAIL t1_state: got %0d expected 0", state_o); else n_pass++;
        n_checks++; if (run_3x3_o !== 1'b0) $display("FAIL t1_run_3x3: got %b expected 0", run_3x3_o); else n_pass++;
        n_checks++; if ({busy_o, done_o, err_o} !== 3'b0)
            $display("FAIL t1_status: got %b expected 000", {busy_o, done_o, err_o}); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd0) $display("FAIL t1_cnt: got %0d expected 0", cycle_cnt_o); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sequence();
        int pe, c3, c2, dsp, dn;
        bit to;
        run_seq(3, 0, 1'b0, pe, c3, c2, dsp, dn, to);
        n_checks++; if (pe !== 3)   $display("FAIL t2_pe_cycles: got %0d expected 3", pe); else n_pass++;
        n_checks++; if (c3 !== 3)   $display("FAIL t2_3x3_cycles: got %0d expected 3", c3); else n_pass++;
        n_checks++; if (c2 !== 3)   $display("FAIL t2_2x2_cycles: got %0d expected 3", c2); else n_pass++;
        n_checks++; if (dsp !== 12) $display("FAIL t2_disp_cycles: got %0d expected 12", dsp); else n_pass++;
        n_checks++; if (dn !== 1)   $display("FAIL t2_done_pulses: got %0d expected 1", dn); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd22) $display("FAIL t2_cnt: got %0d expected 22", cycle_cnt_o); else n_pass++;
        repeat (3) tick();
        n_checks++; if (cycle_cnt_o !== 8'd22) $display("FAIL t2_cnt_frozen: got %0d expected 22", cycle_cnt_o); else n_pass++;
        n_checks++; if ({state_o, busy_o} !== 4'b0000)
            $display("FAIL t2_idle: got state %0d busy %b expected state 0 busy 0", state_o, busy_o); else n_pass++;
    endtask

    task automatic test_timeout();
        int pe, c3, c2, dsp, dn;
        bit to;
        run_seq(0, 0, 1'b0, pe, c3, c2, dsp, dn, to);
        n_checks++; if (pe !== 255) $display("FAIL t3_pe_cycles: got %0d expected 255", pe); else n_pass++;
        n_checks++; if (state_o !== 3'd6) $display("FAIL t3_err_state: got %0d expected 6", state_o); else n_pass++;
        n_checks++; if ({err_o, busy_o, run_pe_o} !== 3'b100)
            $display("FAIL t3_err_flags: got err/busy/run_pe %b expected 100", {err_o, busy_o, run_pe_o}); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd255) $display("FAIL t3_cnt: got %0d expected 255", cycle_cnt_o); else n_pass++;
        tick();
        n_checks++; if (state_o !== 3'd6) $display("FAIL t3_err_holds: got %0d expected 6", state_o); else n_pass++;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++; if ({state_o, err_o} !== 4'b0010)
            $display("FAIL t3_restart: got state %0d err %b expected state 1 err 0", state_o, err_o); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd0) $display("FAIL t3_restart_cnt: got %0d expected 0", cycle_cnt_o); else n_pass++;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_checks++; if ({state_o, run_pe_o} !== 4'b0000)
            $display("FAIL t3_abort_pe: got state %0d run_pe %b expected 0 0", state_o, run_pe_o); else n_pass++;
    endtask

    task automatic test_abort();
        int pe, c3, c2, dsp, dn;
        bit to;
        run_seq(3, 5, 1'b0, pe, c3, c2, dsp, dn, to);
        n_checks++; if (dsp !== 5) $display("FAIL t4_disp_cycles: got %0d expected 5", dsp); else n_pass++;
        n_checks++; if ({state_o, run_display_o} !== 4'b0000)
            $display("FAIL t4_state: got state %0d run_display %b expected 0 0", state_o, run_display_o); else n_pass++;
        n_checks++; if (dn !== 0) $display("FAIL t4_no_done: got %0d pulses expected 0", dn); else n_pass++;
        tick();
        n_checks++; if ({done_o, err_o} !== 2'b00) $display("FAIL t4_status: got %b expected 00", {done_o, err_o}); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd13) $display("FAIL t4_cnt: got %0d expected 13", cycle_cnt_o); else n_pass++;
    endtask

    task automatic test_ignored_inputs();
        int pe, c3, c2, dsp, dn;
        bit to;
        run_seq(3, 0, 1'b1, pe, c3, c2, dsp, dn, to);
        n_checks++; if (pe !== 3) $display("FAIL t5_pe_cycles: got %0d expected 3", pe); else n_pass++;
        n_checks++; if (c3 !== 3) $display("FAIL t5_3x3_cycles: got %0d expected 3", c3); else n_pass++;
        n_checks++; if (c2 !== 3) $display("FAIL t5_2x2_cycles: got %0d expected 3", c2); else n_pass++;
        n_checks++; if (dsp !== 12) $display("FAIL t5_disp_cycles: got %0d expected 12", dsp); else n_pass++;
        n_checks++; if (dn !== 1) $display("FAIL t5_done_pulses: got %0d expected 1", dn); else n_pass++;
        n_checks++; if (cycle_cnt_o !== 8'd22) $display("FAIL t5_cnt: got %0d expected 22", cycle_cnt_o); else n_pass++;
    endtask

    task automatic test_saturate();
        int pe, c3, c2, dsp, dn;
        bit to;
        run_seq(5, 0, 1'b0, pe, c3, c2, dsp, dn, to);
        n_checks++; if (cycle_cnt_o !== 8'd28) $display("FAIL t6_cnt_wide: got %0d expected 28", cycle_cnt_o); else n_pass++;
        n_checks++; if (cycle_cnt_b !== 4'd15) $display("FAIL t6_cnt_sat: got %0d expected 15", cycle_cnt_b); else n_pass++;
        n_checks++; if ({state_b, err_b} !== 4'b0000)
            $display("FAIL t6_small_state: got state %0d err %b expected 0 0", state_b, err_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_sequence();
        test_timeout();
        test_abort();
        test_ignored_inputs();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
